// File: rtl/gamma_spike_sequencer_if.sv
// Gamma-cycle spike sequencer bus: spike inputs, replay-buffer write port and cycle status.
interface gamma_spike_sequencer_if #(
  parameter int unsigned P            = 64,
  parameter int unsigned BUFFER_DEPTH = 16
);
  logic                            grst;
  logic [P-1:0]                    spike_in;
  logic [P-1:0]                    spike_out;
  logic [$clog2(BUFFER_DEPTH)-1:0] wr_idx;
  logic                            wr_en;
  logic                            start_count;
  logic                            buf_sel;
  logic                            cycle_done;
  logic                            truncated;

  modport master (
    output grst, spike_in,
    input  spike_out, wr_idx, wr_en, start_count, buf_sel, cycle_done, truncated
  );

  modport slave (
    input  grst, spike_in,
    output spike_out, wr_idx, wr_en, start_count, buf_sel, cycle_done, truncated
  );
endinterface

// File: rtl/gamma_spike_sequencer.sv
// Passes only the first spike per line in each gamma cycle into a ping-pong replay buffer,
// one slot per clock, restarting on every rising edge of grst.
module gamma_spike_sequencer #(
  parameter int unsigned P                  = 64,
  parameter int unsigned BUFFER_DEPTH       = 16,
  parameter int unsigned GAMMA_CYCLE_LENGTH = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  gamma_spike_sequencer_if.slave    bus
);
  localparam int unsigned CW = $clog2(GAMMA_CYCLE_LENGTH);
  localparam int unsigned IW = $clog2(BUFFER_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_LENGTH - 1);
  // One extra bit so BUFFER_DEPTH == 2**CW still compares correctly.
  localparam logic [CW:0]   WIN  = (CW+1)'(BUFFER_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_count;
  logic           r_buf_sel;
  logic           r_grst_q;
  logic [P-1:0]   r_fired;

  logic           w_edge;
  logic           w_run;
  logic           w_wr_en;
  logic [P-1:0]   w_spike_out;

  assign w_edge = bus.grst & ~r_grst_q;
  assign w_run  = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A grst edge restarts the cycle from any state and beats RUN->HOLD.
  always_comb begin
    w_next = r_state;
    if (w_edge) begin
      w_next = S_RUN;
    end else if (r_state == S_RUN && r_count == LAST) begin
      w_next = S_HOLD;
    end
  end

  always_comb begin
    w_wr_en         = w_run & ({1'b0, r_count} < WIN) & ~w_edge;
    w_spike_out     = bus.spike_in & ~r_fired & {P{w_wr_en}};
    bus.wr_en       = w_wr_en;
    bus.wr_idx      = w_wr_en ? r_count[IW-1:0] : '0;
    bus.spike_out   = w_spike_out;
    bus.start_count = w_run;
    bus.buf_sel     = r_buf_sel;
    // Reset aborts silently, so neither pulse may fire in a reset clock.
    bus.cycle_done  = w_run & (r_count == LAST) & ~w_edge & ~rst;
    bus.truncated   = w_run & w_edge & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_buf_sel <= 1'b0;
      r_grst_q  <= 1'b0;
      r_fired   <= '0;
    end else begin
      r_grst_q <= bus.grst;
      if (w_edge) begin
        r_count   <= '0;
        r_buf_sel <= ~r_buf_sel;
        r_fired   <= '0;
      end else begin
        if (w_run && r_count != LAST) r_count <= r_count + CW'(1);
        r_fired <= r_fired | w_spike_out;
      end
    end
  end
endmodule

// File: tb/tb_gamma_spike_sequencer.sv
// Directed, table-driven check of the gamma spike sequencer at default parameters.
module tb_gamma_spike_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gamma_spike_sequencer_if #(.P(64), .BUFFER_DEPTH(16)) bus ();

  gamma_spike_sequencer #(
    .P(64), .BUFFER_DEPTH(16), .GAMMA_CYCLE_LENGTH(18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        grst;
    logic [63:0] spk;
    logic        en;
    logic [3:0]  idx;
    logic [63:0] out;
    logic        start;
    logic        bsel;
    logic        done;
    logic        trunc;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, input logic g, input logic [63:0] s,
                              input logic en, input int idx, input logic [63:0] o,
                              input logic st, input logic bs, input logic dn, input logic tr);
    vec_t v;
    v.rst = r; v.grst = g; v.spk = s; v.en = en; v.idx = 4'(idx); v.out = o;
    v.start = st; v.bsel = bs; v.done = dn; v.trunc = tr;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int vi, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, vi, act, exp);
    end
  endtask

  task automatic check_all(input int vi, input vec_t v);
    n_vec++;
    chk("wr_en",       vi, 64'(bus.wr_en),       64'(v.en));
    chk("wr_idx",      vi, 64'(bus.wr_idx),      64'(v.idx));
    chk("spike_out",   vi, bus.spike_out,        v.out);
    chk("start_count", vi, 64'(bus.start_count), 64'(v.start));
    chk("buf_sel",     vi, 64'(bus.buf_sel),     64'(v.bsel));
    chk("cycle_done",  vi, 64'(bus.cycle_done),  64'(v.done));
    chk("truncated",   vi, 64'(bus.truncated),   64'(v.trunc));
  endtask

  initial begin
    vec_t zero;
    logic [63:0] s;
    logic [63:0] o;

    // First cycle: idle, then grst edge from IDLE drops the spike that arrives with it.
    add(0, 0, 64'h0,  0, 0, 64'h0, 0, 0, 0, 0);
    add(0, 1, 64'h20, 0, 0, 64'h0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      s = 64'h0; o = 64'h0;
      if (k == 1 || k == 2) s = 64'h8000_0000_0000_0006;
      if (k == 3 || k == 7) s = 64'h20;
      if (k == 15)          s = 64'h200;
      if (k == 1 || k == 3 || k == 15) o = s;
      add(0, 1, s, 1, k, o, 1, 1, 0, 0);
    end
    add(0, 1, 64'h1, 0, 0, 64'h0, 1, 1, 0, 0);   // count 16: outside write window
    add(0, 1, 64'h1, 0, 0, 64'h0, 1, 1, 1, 0);   // count 17: cycle_done
    add(0, 1, 64'h400, 0, 0, 64'h0, 0, 1, 0, 0); // HOLD
    add(0, 0, 64'h400, 0, 0, 64'h0, 0, 1, 0, 0);
    add(0, 0, 64'h0,   0, 0, 64'h0, 0, 1, 0, 0);
    add(0, 1, 64'h20,  0, 0, 64'h0, 0, 1, 0, 0); // edge in HOLD: no truncation
    // Second cycle: fired cleared, truncated by an edge at count 10.
    for (int k = 0; k < 10; k++)
      add(0, (k == 9) ? 1'b0 : 1'b1, (k == 2) ? 64'h20 : 64'h0, 1, k,
          (k == 2) ? 64'h20 : 64'h0, 1, 0, 0, 0);
    add(0, 1, 64'h80, 0, 0, 64'h0, 1, 0, 0, 1);
    // Third cycle: edge coincides with the last count, truncation wins over cycle_done.
    for (int k = 0; k < 16; k++)
      add(0, 1, (k == 0) ? 64'h20 : 64'h0, 1, k, (k == 0) ? 64'h20 : 64'h0, 1, 1, 0, 0);
    add(0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0);
    add(0, 1, 64'h0, 0, 0, 64'h0, 1, 1, 0, 1);
    for (int k = 0; k < 5; k++)
      add(0, 1, 64'h0, 1, k, 64'h0, 1, 0, 0, 0);

    // Reset preamble: three reset clocks with grst low, outputs all zero after the first.
    zero = '{rst:1'b1, grst:1'b0, spk:64'h0, en:1'b0, idx:4'h0, out:64'h0,
             start:1'b0, bsel:1'b0, done:1'b0, trunc:1'b0};
    bus.grst = 1'b0; bus.spike_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      #2;
      if (i > 0) check_all(-1 - i, zero);
    end

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; bus.grst = vq[i].grst; bus.spike_in = vq[i].spk;
      #2;
      check_all(i, vq[i]);
    end

    // Reset at count 5 with grst held high: silent abort, then edge right after release.
    @(negedge clk);
    rst = 1'b1; bus.grst = 1'b1; bus.spike_in = '0;
    #2;
    check_all(100, '{rst:1'b1, grst:1'b1, spk:64'h0, en:1'b1, idx:4'h5, out:64'h0,
                     start:1'b1, bsel:1'b0, done:1'b0, trunc:1'b0});
    @(negedge clk);
    bus.spike_in = 64'h20;
    #2;
    check_all(101, '{rst:1'b1, grst:1'b1, spk:64'h20, en:1'b0, idx:4'h0, out:64'h0,
                     start:1'b0, bsel:1'b0, done:1'b0, trunc:1'b0});
    @(negedge clk);
    rst = 1'b0; bus.spike_in = 64'h20;
    #2;
    check_all(102, '{rst:1'b0, grst:1'b1, spk:64'h20, en:1'b0, idx:4'h0, out:64'h0,
                     start:1'b0, bsel:1'b0, done:1'b0, trunc:1'b0});
    @(negedge clk);
    #2;
    check_all(103, '{rst:1'b0, grst:1'b1, spk:64'h20, en:1'b1, idx:4'h0, out:64'h20,
                     start:1'b1, bsel:1'b1, done:1'b0, trunc:1'b0});
    @(negedge clk);
    #2;
    check_all(104, '{rst:1'b0, grst:1'b1, spk:64'h20, en:1'b1, idx:4'h1, out:64'h0,
                     start:1'b1, bsel:1'b1, done:1'b0, trunc:1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1);
  end
endmodule

// File: doc/gamma_spike_sequencer.md
GAMMA_SPIKE_SEQUENCER -- requirements
Module: gamma_spike_sequencer

Interface
REQ-001 SHALL have parameter P, default 64, meaning number of spike input lines.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 16, meaning number of replay-buffer slots per gamma cycle (power of 2).
REQ-003 SHALL have parameter GAMMA_CYCLE_LENGTH, default 18, meaning clocks per gamma cycle; constraint GAMMA_CYCLE_LENGTH >= BUFFER_DEPTH.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port grst  input  1  gamma reset level; its rising edge starts a gamma cycle.
REQ-007 SHALL have port spike_in  input  P  raw spike lines, sampled every clock.
REQ-008 SHALL have port spike_out  output  P  first-spike-only data to the replay buffer write port.
REQ-009 SHALL have port wr_idx  output  $clog2(BUFFER_DEPTH)  replay-buffer write slot.
REQ-010 SHALL have port wr_en  output  1  high when spike_out/wr_idx are valid for writing.
REQ-011 SHALL have port start_count  output  1  high while a gamma cycle is running.
REQ-012 SHALL have port buf_sel  output  1  ping-pong bank select, toggled per gamma cycle.
REQ-013 SHALL have port cycle_done  output  1  one-clock pulse at normal end of a gamma cycle.
REQ-014 SHALL have port truncated  output  1  one-clock pulse when a gamma cycle is aborted by an early grst edge.

Function
REQ-015 SHALL register grst into grst_q each clock; edge = grst & ~grst_q (combinational, same cycle).
REQ-016 SHALL implement FSM states IDLE, RUN, HOLD; IDLE->RUN on edge; RUN->HOLD when count == GAMMA_CYCLE_LENGTH-1; HOLD->RUN on edge.
REQ-017 SHALL, on every edge (any state), at that clock's posedge set count=0, toggle buf_sel, clear all fired bits, enter RUN.
REQ-018 SHALL increment count by 1 each RUN clock; count width $clog2(GAMMA_CYCLE_LENGTH), no wrap beyond GAMMA_CYCLE_LENGTH-1.
REQ-019 SHALL drive start_count = (state == RUN).
REQ-020 SHALL drive wr_en = (state == RUN) & (count < BUFFER_DEPTH) & ~edge.
REQ-021 SHALL drive wr_idx = count[$clog2(BUFFER_DEPTH)-1:0] when wr_en, else 0.
REQ-022 SHALL drive spike_out[i] = spike_in[i] & ~fired[i] & wr_en (combinational, same cycle as wr_idx).
REQ-023 SHALL set fired[i] at posedge when spike_out[i]==1; fired holds until next edge or rst.
REQ-024 SHALL drop spikes arriving while wr_en==0 (IDLE, HOLD, edge cycle, count >= BUFFER_DEPTH); such spikes do not set fired.
REQ-025 SHALL pulse cycle_done for exactly the RUN clock where count == GAMMA_CYCLE_LENGTH-1, unless edge is high that clock.
REQ-026 SHALL pulse truncated in a clock where edge==1 and state==RUN (and not cycle_done condition suppressed by it); restart per REQ-017 proceeds.
REQ-027 SHALL give edge priority over the RUN->HOLD transition when both occur in the same clock.

Reset
REQ-028 SHALL on rst: state=IDLE, count=0, buf_sel=0, fired=0, grst_q=0; thus spike_out=0, wr_idx=0, wr_en=0, start_count=0, cycle_done=0, truncated=0.
REQ-029 SHALL let rst override edge; rst mid-RUN aborts silently (no truncated pulse); a grst held high through rst release produces an edge on the first clock after release (grst_q=0).

Verification
REQ-030 SHALL cover: rst 3 clocks, grst low -> all outputs 0, state IDLE.
REQ-031 SHALL cover: grst 0->1 at clock T -> clocks T+1..T+16 wr_en=1, wr_idx 0..15; T+17,T+18 wr_en=0, start_count=1; cycle_done pulse at T+18; HOLD from T+19; buf_sel=1.
REQ-032 SHALL cover: spike_in[5]=1 at wr_idx 3 and 7 -> spike_out[5]=1 only at wr_idx 3; spike_in[0]=1 at count 16 -> spike_out[0]=0.
REQ-033 SHALL cover: second grst edge at count 10 -> truncated=1 that clock, no cycle_done, next clock wr_idx=0, buf_sel toggles back to 0, fired cleared (spike_in[5] passes again).
REQ-034 SHALL cover: rst asserted at count 5 with grst held high -> outputs reset; after release, edge detected first clock, RUN with wr_idx=0 next clock, buf_sel=1.
